// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            stall_o;

  // EX-stage side: issues the operation, observes progress and result
  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
    input  busy_o, done_o, result_o, stall_o
  );

  // Unit side
  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
    output busy_o, done_o, result_o, stall_o
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// unsigned magnitudes, one bit per cycle, with signs re-applied in a final FIX cycle.
module mdu_iterative #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 6
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mdu_iterative_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(XLEN-1);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (MUL*) or divisor (DIV*/REM*)
  logic [2*XLEN-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at capture time
  logic            is_div_in, signed_a, signed_b, a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            special;
  logic [XLEN-1:0] special_res;

  assign is_div_in = bus.funct3_i[2];
  // Only MULHU/DIVU/REMU treat rs1 as unsigned
  assign signed_a  = !(bus.funct3_i[0] && (bus.funct3_i[1] || bus.funct3_i[2]));
  // rs2 is signed for MUL/MULH and DIV/REM only
  assign signed_b  = bus.funct3_i[2] ? !bus.funct3_i[0] : !bus.funct3_i[1];
  assign a_neg_in  = signed_a && bus.rs1_data_i[XLEN-1];
  assign b_neg_in  = signed_b && bus.rs2_data_i[XLEN-1];
  assign a_mag     = a_neg_in ? -bus.rs1_data_i : bus.rs1_data_i;
  assign b_mag     = b_neg_in ? -bus.rs2_data_i : bus.rs2_data_i;

  // Divide-by-zero and signed overflow have fixed architectural results and skip iteration
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div_in) begin
      if (bus.rs2_data_i == '0) begin
        special     = 1'b1;
        special_res = bus.funct3_i[1] ? bus.rs1_data_i : ALL_ONES;
      end else if (!bus.funct3_i[0] && bus.rs1_data_i == MIN_NEG && bus.rs2_data_i == ALL_ONES) begin
        special     = 1'b1;
        special_res = bus.funct3_i[1] ? '0 : MIN_NEG;
      end
    end
  end

  // One iteration step for each algorithm
  logic [XLEN:0]     mul_sum, rem_shift;
  logic [XLEN-1:0]   rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] mul_step, div_step;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step  = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_shift = acc_q[2*XLEN-1:XLEN-1];
  assign rem_ge    = rem_shift >= {1'b0, opnd_q};
  // The difference fits in XLEN bits whenever it is used, since remainder < divisor
  assign rem_diff  = rem_shift[XLEN-1:0] - opnd_q;
  assign div_step  = rem_ge ? {rem_diff, acc_q[XLEN-2:0], 1'b1}
                            : {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  // Sign fix-up and result selection
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res;

  assign prod_s  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quot_s  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_s   = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_res = op_q[2] ? (op_q[1] ? rem_s : quot_s)
                           : ((op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  // Next-state and datapath update; everything holds unless a state says otherwise
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            op_d    = bus.funct3_i;
            neg_a_d = a_neg_in;
            neg_b_d = b_neg_in;
            cnt_d   = '0;
            opnd_d  = is_div_in ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
            if (special) begin
              result_d = special_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_ITER;
            end
          end
        end
        S_ITER: begin
          acc_d = op_q[2] ? div_step : mul_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = (state_q == S_ITER) || (state_q == S_FIX);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = result_q;
  // Freeze the pipeline from the accepting cycle until the result is ready; released in DONE
  assign bus.stall_o  = rst_ni && (((state_q == S_IDLE) && bus.start_i && !bus.flush_i) || bus.busy_o);

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes the forwarded operands (the outputs of the EX-stage forwarding muxes) as rs1_data_i/rs2_data_i.
- Runs one multi-cycle MUL*/DIV*/REM* operation at a time and holds the pipeline via stall_o until the result is ready.
- Result is written back through the normal EX/MEM path in the cycle done_o is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER_W, 6, width of the iteration counter; must hold XLEN.

Ports:
- clk_i  input  1  rising-edge clock.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  EX-stage instruction is an M-extension op; operands valid this cycle.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  input  32  forwarded operand A (dividend / multiplicand).
- rs2_data_i  input  32  forwarded operand B (divisor / multiplier).
- flush_i  input  1  pipeline flush; aborts any operation.
- busy_o  output  1  operation in progress (ITER or FIX state).
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  32  registered result, held until the next completion.
- stall_o  output  1  freeze IF/ID/EX; combinational.

Behaviour:
- Reset: while rst_ni = 0, state = IDLE and busy_o = done_o = result_o = 0. stall_o is forced to 0. All internal registers are cleared. An operation in progress at reset is discarded.
- States: IDLE, ITER, FIX, DONE.
- IDLE -> ITER when start_i = 1 and flush_i = 0 at a clock edge (call it T0).
  - Operands, funct3 and operand signs are captured at T0.
  - Signedness: MUL/MULH/DIV/REM both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned.
  - Operands are converted to magnitudes at capture.
- Special cases skip ITER/FIX and go IDLE -> DONE, so done_o is high in cycle T0+1:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = rs1.
  - DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same = 0.
- ITER: exactly 32 cycles (T0+1..T0+32), counter 0..31.
  - Multiply: radix-2 shift-add into a 64-bit unsigned product.
  - Divide: restoring division, one quotient bit per cycle; 32-bit quotient and remainder magnitudes.
- FIX (T0+33): apply signs.
  - Product negated (64-bit two's complement) if the operand signs differ.
  - Quotient negated if sign(A) xor sign(B); remainder takes sign(A).
  - Select result: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV*/REM* = quotient/remainder.
- DONE (T0+34): done_o = 1 and result_o updated for this cycle and held afterwards. Next state is always IDLE.
- busy_o = 1 in ITER and FIX, otherwise 0.
- stall_o = rst_ni & ((IDLE & start_i & !flush_i) | busy_o). It is 0 in DONE so the pipeline advances with the result.
- start_i outside IDLE is ignored.
- flush_i = 1 in any state -> IDLE at the next edge.
  - No done_o; result_o unchanged.
  - flush_i with start_i in IDLE: the op is not accepted.
  - flush_i in DONE: done_o still pulses this cycle; the state returns to IDLE.
- Total stall for a normal op: 34 cycles; result visible in EX at cycle T0+34.

Test Plan:
1. MUL: rs1 = 7, rs2 = 0xFFFFFFFD (-3), start at T0 -> stall_o high T0..T0+33; done_o only at T0+34; result_o = 0xFFFFFFEB.
2. High multiplies, all with rs1 = rs2 = 0xFFFFFFFF except the first:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
3. Divides:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
   - DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
4. Special cases, each with done_o at T0+1 and stall_o high only in cycle T0:
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
5. Flush and busy handling:
   - flush_i at T0+10 of a DIVU -> IDLE at T0+11; no done_o; result_o keeps its prior value.
   - start_i pulsed at T0+5 of a running op -> ignored.
   - Back-to-back ops: second start in the cycle after DONE is accepted.
6. Reset mid-operation: rst_ni low at T0+20 -> busy_o/stall_o/result_o = 0 immediately. After release, MULHU 3 x 5 -> result 0, completing at T0'+34.
